hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing unit for the 5-stage MIPS core.
- Consumes decoded per-stage control and register indices; produces the Stall/Flush strobes that gate the pipeline control/data registers, plus the forwarding selects.
- Contains the multi-cycle divider sequencer, so EX can be held while the iterative divider runs.
- Sits beside the controller and datapath, between decode and the pipeline registers.

Parameters:
- DIV_CYCLES, 32, cycles the iterative divider needs from start to valid result.
- CNT_W, 6, width of the divider cycle counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- RsD, RtD  in  5 each  source registers in ID
- RsE, RtE  in  5 each  source registers in EX
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enable per stage
- MemReadE, MemReadM  in  1 each  load in EX / MEM
- BranchD  in  2  branch type in ID; nonzero means branch
- JumpSrcD  in  1  register-indirect jump (jr/jalr) in ID
- DivE  in  1  div/divu in EX
- ExceptM  in  1  exception or eret committed in MEM
- ForwardAD, ForwardBD  out  1 each  ID comparator operand from MEM result
- ForwardAE, ForwardBE  out  2 each  EX operand select: 00 reg file, 01 WB, 10 MEM
- StallF, StallD, StallE  out  1 each  hold PC / IF-ID / ID-EX
- FlushD, FlushE, FlushM, FlushW  out  1 each  clear IF-ID / ID-EX / EX-MEM / MEM-WB
- DivBusy  out  1  divider running
- DivStart  out  1  one-cycle strobe that launches the divider

Behaviour:
- Reset: async on rst=1. FSM goes to IDLE and the counter to 0. All Stall*, Flush*, DivBusy, DivStart are 0 while rst=1.
- Register 0 never matches for forwarding or hazard detection.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && WriteRegM==RsE; else 01 if RegWriteW && WriteRegW==RsE; else 00.
  - ForwardBE uses the same rule with RtE.
  - ForwardAD/BD=1 if RegWriteM && WriteRegM==RsD/RtD.
- lwstall = MemReadE && (RtE==RsD || RtE==RtD).
- brstall = (BranchD!=0 || JumpSrcD) && ((RegWriteE && WriteRegE matches RsD/RtD) || (MemReadM && WriteRegM matches RsD/RtD)).
- Divider FSM:
  - IDLE: if DivE && !ExceptM, assert DivStart for 1 cycle and go to BUSY with cnt=0.
  - BUSY: cnt increments each cycle. At cnt==DIV_CYCLES-1, go to DONE.
  - DONE: 1 cycle, releases the stall, then IDLE. The DONE cycle must not relaunch on the same DivE (instruction still in EX); IDLE is re-entered only after EX advances.
- divstall = DivE && state!=DONE. This includes the IDLE launch cycle. Total EX hold for one div is DIV_CYCLES+1 cycles.
- DivBusy = state==BUSY.
- Stall/flush equations:
  - StallF = StallD = lwstall || brstall || divstall.
  - StallE = divstall.
  - FlushE = (lwstall || brstall) && !divstall. A bubble enters EX only when EX itself advances.
  - FlushM = divstall. A bubble enters MEM while EX is held.
- Exception priority: ExceptM=1 overrides everything that cycle.
  - FlushD=FlushE=FlushM=FlushW=1 and all Stall*=0.
  - If the FSM is BUSY or DONE, it aborts to IDLE at the next edge and cnt clears.
- No other flush sources; branch-delay slots are never flushed.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, add output StallCnt (32 bits). It increments each cycle that StallF=1 and ExceptM=0, resets to 0 on rst, and wraps at 2^32.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- lw $2 in EX (MemReadE=1, RtE=2), RsD=2 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Next cycle ForwardAE=01 when RsE=2 and WriteRegW=2.
- add writes $5 in EX, beq in ID with RsD=5 -> brstall 1 cycle. Next cycle ForwardAD=1, no stall.
- DivE=1 held, DIV_CYCLES=32 -> DivStart pulses once, DivBusy=1 for 32 cycles, StallE=1 for 33 cycles, FlushM=1 each of those, then 0.
- ExceptM=1 on the 10th BUSY cycle -> all four Flush=1 that cycle, all Stall=0, FSM IDLE next cycle, DivBusy=0.
- RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=RsE=7 -> ForwardAE=10 (MEM wins). RsE=0 with WriteRegM=0 -> 00.
- rst asserted mid-BUSY (cnt=15) -> DivBusy and all Stall/Flush 0 immediately (asynchronous). After release, IDLE relaunches if DivE=1.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard unit bus: decoded per-stage control in, stall/flush/forward strobes out.
// master = decode/datapath side, slave = hazard_ctrl.
interface hazard_if;
   logic [4:0] RsD, RtD, RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemReadE, MemReadM;
   logic [1:0] BranchD;
   logic       JumpSrcD, DivE, ExceptM;
   logic       ForwardAD, ForwardBD;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE;
   logic       FlushD, FlushE, FlushM, FlushW;
   logic       DivBusy, DivStart;

   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM,
             BranchD, JumpSrcD, DivE, ExceptM,
      input  ForwardAD, ForwardBD, ForwardAE, ForwardBE,
             StallF, StallD, StallE, FlushD, FlushE, FlushM, FlushW,
             DivBusy, DivStart
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM,
             BranchD, JumpSrcD, DivE, ExceptM,
      output ForwardAD, ForwardBD, ForwardAE, ForwardBE,
             StallF, StallD, StallE, FlushD, FlushE, FlushM, FlushW,
             DivBusy, DivStart
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / sequencing unit for the 5-stage MIPS core.
// Forwarding selects, load-use and branch-operand stalls, exception flushes,
// and the iterative-divider sequencer that holds EX while the divide runs.
// Optional: define HAZARD_PERF_CNT_EN to add the 32-bit StallCnt output.
module hazard_ctrl #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0] StallCnt,
`endif
   hazard_if.slave     hz
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_start;
   logic             lwstall, brstall, divstall, stall_any;

   // $0 is hard-wired, so it never produces a match
   function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

   // forwarding selects; MEM result is newer than WB so it wins
   always_comb begin
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
      if (hz.RegWriteM && hit(hz.WriteRegM, hz.RsE))      hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && hit(hz.WriteRegW, hz.RsE)) hz.ForwardAE = 2'b01;
      if (hz.RegWriteM && hit(hz.WriteRegM, hz.RtE))      hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && hit(hz.WriteRegW, hz.RtE)) hz.ForwardBE = 2'b01;
      hz.ForwardAD = hz.RegWriteM && hit(hz.WriteRegM, hz.RsD);
      hz.ForwardBD = hz.RegWriteM && hit(hz.WriteRegM, hz.RtD);
   end

   // hazard terms; the divide stall drops in DONE so EX advances that cycle
   always_comb begin
      lwstall   = hz.MemReadE && (hit(hz.RtE, hz.RsD) || hit(hz.RtE, hz.RtD));
      brstall   = ((hz.BranchD != 2'b00) || hz.JumpSrcD) &&
                  ((hz.RegWriteE && (hit(hz.WriteRegE, hz.RsD) || hit(hz.WriteRegE, hz.RtD))) ||
                   (hz.MemReadM  && (hit(hz.WriteRegM, hz.RsD) || hit(hz.WriteRegM, hz.RtD))));
      divstall  = hz.DivE && (state_q != DONE);
      stall_any = lwstall || brstall || divstall;
   end

   // divider sequencer next state; an exception aborts any divide in flight
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_start = 1'b0;
      case (state_q)
         IDLE: if (hz.DivE && !hz.ExceptM) begin
            div_start = 1'b1;
            state_d   = BUSY;
            cnt_d     = '0;
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (hz.ExceptM) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   // divider state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // stall/flush strobes; reset forces them quiet, exception overrides hazards
   always_comb begin
      hz.StallF   = 1'b0;
      hz.StallD   = 1'b0;
      hz.StallE   = 1'b0;
      hz.FlushD   = 1'b0;
      hz.FlushE   = 1'b0;
      hz.FlushM   = 1'b0;
      hz.FlushW   = 1'b0;
      hz.DivStart = 1'b0;
      hz.DivBusy  = (state_q == BUSY) && !rst;
      if (!rst) begin
         hz.DivStart = div_start;
         if (hz.ExceptM) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
            hz.FlushM = 1'b1;
            hz.FlushW = 1'b1;
         end else begin
            hz.StallF = stall_any;
            hz.StallD = stall_any;
            hz.StallE = divstall;
            hz.FlushE = (lwstall || brstall) && !divstall;
            hz.FlushM = divstall;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // count front-end stall cycles, wrapping naturally
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_any && !hz.ExceptM) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // stall counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a cycle-age model of the divider.
module tb_hazard_ctrl;
   localparam int DIV = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   hazard_if hz();
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] StallCnt;
   hazard_ctrl #(.DIV_CYCLES(DIV), .CNT_W(6)) dut (.clk(clk), .rst(rst), .StallCnt(StallCnt), .hz(hz));
`else
   hazard_ctrl #(.DIV_CYCLES(DIV), .CNT_W(6)) dut (.clk(clk), .rst(rst), .hz(hz));
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ad, bd;
      logic [1:0] ae, be;
      logic       sf, sd, se, fd, fe, fm, fw, busy, start;
   } exp_t;

   // divider model: -1 = no divide, else cycles elapsed since the launch cycle
   int          div_age;
   logic [31:0] m_cnt;

   function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit lw, br, dv, idle, done;
      e = '0;
      e.ae = (hz.RegWriteM && hit(hz.WriteRegM, hz.RsE)) ? 2'd2 :
             (hz.RegWriteW && hit(hz.WriteRegW, hz.RsE)) ? 2'd1 : 2'd0;
      e.be = (hz.RegWriteM && hit(hz.WriteRegM, hz.RtE)) ? 2'd2 :
             (hz.RegWriteW && hit(hz.WriteRegW, hz.RtE)) ? 2'd1 : 2'd0;
      e.ad = hz.RegWriteM && hit(hz.WriteRegM, hz.RsD);
      e.bd = hz.RegWriteM && hit(hz.WriteRegM, hz.RtD);
      idle = (div_age < 0);
      done = (div_age == DIV + 1);
      e.busy = !idle && !done && !rst;
      if (rst) return e;
      lw = hz.MemReadE && (hit(hz.RtE, hz.RsD) || hit(hz.RtE, hz.RtD));
      br = (hz.BranchD != 0 || hz.JumpSrcD) &&
           ((hz.RegWriteE && (hit(hz.WriteRegE, hz.RsD) || hit(hz.WriteRegE, hz.RtD))) ||
            (hz.MemReadM  && (hit(hz.WriteRegM, hz.RsD) || hit(hz.WriteRegM, hz.RtD))));
      dv = hz.DivE && !done;
      e.start = idle && hz.DivE && !hz.ExceptM;
      if (hz.ExceptM) begin
         {e.fd, e.fe, e.fm, e.fw} = 4'b1111;
      end else begin
         e.sf = lw || br || dv;
         e.sd = e.sf;
         e.se = dv;
         e.fe = (lw || br) && !dv;
         e.fm = dv;
      end
      return e;
   endfunction

   // advance the model on each edge the DUT sees
   always @(posedge clk or posedge rst) begin : upd
      exp_t t;
      if (rst) begin
         div_age <= -1;
         m_cnt   <= '0;
      end else begin
         t = model_out();
         if (t.sf && !hz.ExceptM) m_cnt <= m_cnt + 32'd1;
         if (hz.ExceptM)               div_age <= -1;
         else if (div_age < 0)         div_age <= hz.DivE ? 1 : -1;
         else if (div_age == DIV + 1)  div_age <= -1;
         else                          div_age <= div_age + 1;
      end
   end

   task automatic clr();
      hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
      hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
      hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
      hz.MemReadE = 0; hz.MemReadM = 0; hz.BranchD = 0;
      hz.JumpSrcD = 0; hz.DivE = 0; hz.ExceptM = 0;
   endtask

   task automatic test_reset();
      clr();
      hz.DivE = 1; hz.MemReadE = 1; hz.RtE = 2; hz.RsD = 2;
      #1;
      checks++;
      if ({hz.StallF, hz.StallD, hz.StallE, hz.FlushE, hz.FlushM, hz.DivStart, hz.DivBusy} !== 7'b0) begin
         errors++; $display("FAIL reset_quiet got %b exp 0000000",
            {hz.StallF, hz.StallD, hz.StallE, hz.FlushE, hz.FlushM, hz.DivStart, hz.DivBusy});
      end
      hz.ExceptM = 1; #1;
      checks++;
      if ({hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW} !== 4'b0) begin
         errors++; $display("FAIL reset_except got %b exp 0000", {hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW});
      end
      @(negedge clk); clr(); rst = 0;
      @(negedge clk);
   endtask

   task automatic test_lwstall();
      @(negedge clk); clr();
      hz.MemReadE = 1; hz.RtE = 2; hz.RsD = 2; hz.RegWriteE = 1; hz.WriteRegE = 2;
      #1; checks++;
      if ({hz.StallF, hz.StallD, hz.FlushE, hz.StallE} !== 4'b1110) begin
         errors++; $display("FAIL lw_stall got %b exp 1110", {hz.StallF, hz.StallD, hz.FlushE, hz.StallE});
      end
      @(negedge clk); clr();
      hz.RsE = 2; hz.RegWriteW = 1; hz.WriteRegW = 2; hz.RsD = 2;
      #1; checks++;
      if ({hz.ForwardAE, hz.StallF, hz.FlushE} !== 4'b0100) begin
         errors++; $display("FAIL lw_fwd got %b exp 0100", {hz.ForwardAE, hz.StallF, hz.FlushE});
      end
      @(negedge clk); clr();
      hz.MemReadE = 1; hz.RtE = 0; hz.RsD = 0;
      #1; checks++;
      if (hz.StallF !== 1'b0) begin
         errors++; $display("FAIL lw_reg0 got %b exp 0", hz.StallF);
      end
   endtask

   task automatic test_brstall();
      @(negedge clk); clr();
      hz.RegWriteE = 1; hz.WriteRegE = 5; hz.BranchD = 2'd1; hz.RsD = 5;
      #1; checks++;
      if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b111) begin
         errors++; $display("FAIL br_stall got %b exp 111", {hz.StallF, hz.StallD, hz.FlushE});
      end
      @(negedge clk); clr();
      hz.RegWriteM = 1; hz.WriteRegM = 5; hz.BranchD = 2'd1; hz.RsD = 5;
      #1; checks++;
      if ({hz.ForwardAD, hz.StallF} !== 2'b10) begin
         errors++; $display("FAIL br_fwd got %b exp 10", {hz.ForwardAD, hz.StallF});
      end
      @(negedge clk); clr();
      hz.MemReadM = 1; hz.WriteRegM = 3; hz.RtD = 3; hz.JumpSrcD = 1;
      #1; checks++;
      if ({hz.StallF, hz.ForwardBD} !== 2'b10) begin
         errors++; $display("FAIL jr_load got %b exp 10", {hz.StallF, hz.ForwardBD});
      end
   endtask

   task automatic test_forward_prio();
      @(negedge clk); clr();
      hz.RegWriteM = 1; hz.RegWriteW = 1; hz.WriteRegM = 7; hz.WriteRegW = 7; hz.RsE = 7; hz.RtE = 7;
      #1; checks++;
      if ({hz.ForwardAE, hz.ForwardBE} !== 4'b1010) begin
         errors++; $display("FAIL fwd_mem_wins got %b exp 1010", {hz.ForwardAE, hz.ForwardBE});
      end
      hz.RsE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0; hz.RtE = 0;
      #1; checks++;
      if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0000) begin
         errors++; $display("FAIL fwd_reg0 got %b exp 0000", {hz.ForwardAE, hz.ForwardBE});
      end
      hz.RegWriteM = 0; hz.WriteRegW = 9; hz.RtE = 9;
      #1; checks++;
      if (hz.ForwardBE !== 2'b01) begin
         errors++; $display("FAIL fwd_wb got %b exp 01", hz.ForwardBE);
      end
   endtask

   task automatic test_div();
      int n_start = 0, n_busy = 0, n_se = 0;
      logic es, eb, est;
      for (int c = 0; c <= DIV + 1; c++) begin
         @(negedge clk); clr(); hz.DivE = 1; #1;
         es = (c == 0); eb = (c >= 1 && c <= DIV); est = (c <= DIV);
         n_start += int'(hz.DivStart); n_busy += int'(hz.DivBusy); n_se += int'(hz.StallE);
         checks++;
         if ({hz.DivStart, hz.DivBusy, hz.StallE, hz.FlushM, hz.StallF} !== {es, eb, est, est, est}) begin
            errors++; $display("FAIL div_cycle%0d got %b exp %b", c,
               {hz.DivStart, hz.DivBusy, hz.StallE, hz.FlushM, hz.StallF}, {es, eb, est, est, est});
         end
      end
      checks++;
      if (n_start != 1 || n_busy != DIV || n_se != DIV + 1) begin
         errors++; $display("FAIL div_totals got %0d/%0d/%0d exp 1/%0d/%0d", n_start, n_busy, n_se, DIV, DIV + 1);
      end
      @(negedge clk); clr(); #1; checks++;
      if ({hz.DivBusy, hz.StallE} !== 2'b00) begin
         errors++; $display("FAIL div_after got %b exp 00", {hz.DivBusy, hz.StallE});
      end
   endtask

   task automatic test_except();
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk); clr(); hz.DivE = 1;
         if (c == 10) hz.ExceptM = 1;
      end
      #1; checks++;
      if ({hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW, hz.StallF, hz.StallD, hz.StallE, hz.DivBusy} !== 8'b11110001) begin
         errors++; $display("FAIL except_busy got %b exp 11110001",
            {hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW, hz.StallF, hz.StallD, hz.StallE, hz.DivBusy});
      end
      @(negedge clk); clr(); #1; checks++;
      if ({hz.DivBusy, hz.StallE, hz.FlushM} !== 3'b000) begin
         errors++; $display("FAIL except_abort got %b exp 000", {hz.DivBusy, hz.StallE, hz.FlushM});
      end
      @(negedge clk); clr(); hz.DivE = 1; hz.ExceptM = 1; #1; checks++;
      if (hz.DivStart !== 1'b0) begin
         errors++; $display("FAIL except_nolaunch got %b exp 0", hz.DivStart);
      end
      @(negedge clk); clr(); #1; checks++;
      if (hz.DivBusy !== 1'b0) begin
         errors++; $display("FAIL except_idle got %b exp 0", hz.DivBusy);
      end
   endtask

   task automatic test_reset_mid_busy();
      for (int c = 0; c <= 16; c++) begin
         @(negedge clk); clr(); hz.DivE = 1;
      end
      #1; checks++;
      if (hz.DivBusy !== 1'b1) begin
         errors++; $display("FAIL rst_pre got %b exp 1", hz.DivBusy);
      end
      #1; rst = 1; hz.MemReadE = 1; hz.RtE = 2; hz.RsD = 2;
      #1; checks++;
      if ({hz.DivBusy, hz.StallF, hz.StallD, hz.StallE, hz.FlushE, hz.FlushM} !== 6'b0) begin
         errors++; $display("FAIL rst_async got %b exp 000000",
            {hz.DivBusy, hz.StallF, hz.StallD, hz.StallE, hz.FlushE, hz.FlushM});
      end
      @(negedge clk); rst = 0; clr(); hz.DivE = 1; #1; checks++;
      if ({hz.DivStart, hz.StallE} !== 2'b11) begin
         errors++; $display("FAIL rst_relaunch got %b exp 11", {hz.DivStart, hz.StallE});
      end
      @(negedge clk); clr();
   endtask

   task automatic test_random();
      exp_t e, g;
      @(negedge clk); rst = 1; clr(); #1;
      @(negedge clk); rst = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         hz.RsD = 5'($urandom_range(0, 3)); hz.RtD = 5'($urandom_range(0, 3));
         hz.RsE = 5'($urandom_range(0, 3)); hz.RtE = 5'($urandom_range(0, 3));
         hz.WriteRegE = 5'($urandom_range(0, 3)); hz.WriteRegM = 5'($urandom_range(0, 3));
         hz.WriteRegW = 5'($urandom_range(0, 3));
         hz.RegWriteE = 1'($urandom); hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
         hz.MemReadE = ($urandom_range(0, 3) == 0); hz.MemReadM = ($urandom_range(0, 3) == 0);
         hz.BranchD = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
         hz.JumpSrcD = ($urandom_range(0, 7) == 0);
         if (div_age >= 0 && div_age <= DIV) hz.DivE = ($urandom_range(0, 7) != 0);
         else                                hz.DivE = ($urandom_range(0, 9) == 0);
         hz.ExceptM = ($urandom_range(0, 39) == 0);
         #1;
         e = model_out();
         g = {hz.ForwardAD, hz.ForwardBD, hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE,
              hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW, hz.DivBusy, hz.DivStart};
         checks++;
         if (g !== e) begin
            errors++; $display("FAIL rand_cycle%0d got %b exp %b", n, g, e);
         end
`ifdef HAZARD_PERF_CNT_EN
         checks++;
         if (StallCnt !== m_cnt) begin
            errors++; $display("FAIL rand_stallcnt%0d got %0d exp %0d", n, StallCnt, m_cnt);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_lwstall();
      test_brstall();
      test_forward_prio();
      test_div();
      test_except();
      test_reset_mid_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
